// File: rtl/snake_game_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snake_game_controller                                                    |
// | Move-tick sequencer, head stepper, lives/length keeper and game flow.    |
// | Optional feature macro: WRAP_AROUND_EN (head wraps at playfield edges).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module snake_game_controller #(
  parameter int COORD_WIDTH    = 10,
  parameter int LENGTH_WIDTH   = 6,
  parameter int MAX_LENGTH     = 63,
  parameter int DISPLAY_WIDTH  = 64,
  parameter int DISPLAY_HEIGHT = 48,
  parameter int TICK_DIV       = 10,
  parameter int START_X        = 10,
  parameter int START_Y        = 10,
  parameter int START_LENGTH   = 3,
  parameter int START_LIVES    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              dir_in,
  input  logic                    dir_valid,
  input  logic                    body_hit,
  input  logic                    food_eaten,
  input  logic [1:0]              fruit_type,
  output logic [COORD_WIDTH-1:0]  head_x,
  output logic [COORD_WIDTH-1:0]  head_y,
  output logic [1:0]              direction,
  output logic                    move_strobe,
  output logic                    grow,
  output logic [LENGTH_WIDTH-1:0] snake_length,
  output logic [2:0]              lives,
  output logic                    respawn,
  output logic                    game_over,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_MOVE    = 3'd2,
    S_CHECK   = 3'd3,
    S_HIT     = 3'd4,
    S_RESPAWN = 3'd5,
    S_OVER    = 3'd6
  } state_t;

  localparam int c_tick_w    = $clog2(TICK_DIV);
  localparam int c_len_ext_w = LENGTH_WIDTH + 2;

  localparam logic [c_tick_w-1:0]     c_tick_last   = c_tick_w'(TICK_DIV - 1);
  localparam logic [COORD_WIDTH-1:0]  c_x_max       = COORD_WIDTH'(DISPLAY_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0]  c_y_max       = COORD_WIDTH'(DISPLAY_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0]  c_start_x     = COORD_WIDTH'(START_X);
  localparam logic [COORD_WIDTH-1:0]  c_start_y     = COORD_WIDTH'(START_Y);
  localparam logic [LENGTH_WIDTH-1:0] c_start_len   = LENGTH_WIDTH'(START_LENGTH);
  localparam logic [c_len_ext_w-1:0]  c_len_max     = c_len_ext_w'(MAX_LENGTH);
  localparam logic [c_len_ext_w-1:0]  c_len_min     = c_len_ext_w'(START_LENGTH);
  localparam logic [2:0]              c_start_lives = 3'(START_LIVES);
  localparam logic [2:0]              c_lives_max   = 3'd7;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [c_tick_w-1:0]     r_tick_cnt;
  logic [1:0]              r_pending_dir;

  logic [1:0]              w_move_dir;
  logic [COORD_WIDTH-1:0]  w_next_x;
  logic [COORD_WIDTH-1:0]  w_next_y;
  logic                    w_edge;
  logic                    w_out_of_bounds;
  logic [c_len_ext_w-1:0]  w_len_ext;
  logic [c_len_ext_w-1:0]  w_len_sum;
  logic [LENGTH_WIDTH-1:0] w_fruit_len;
  logic [2:0]              w_lives_inc;

  assign state = r_state;

  // A request for the exact opposite heading is dropped; the snake keeps going.
  always_comb begin
    w_move_dir = (r_pending_dir == (direction ^ 2'd1)) ? direction : r_pending_dir;
    w_next_x   = head_x;
    w_next_y   = head_y;
    w_edge     = 1'b0;
    case (w_move_dir)
      2'd0: begin
        if (head_x >= c_x_max) begin
          w_edge   = 1'b1;
          w_next_x = '0;
        end else begin
          w_next_x = head_x + COORD_WIDTH'(1);
        end
      end
      2'd1: begin
        if (head_x == '0) begin
          w_edge   = 1'b1;
          w_next_x = c_x_max;
        end else begin
          w_next_x = head_x - COORD_WIDTH'(1);
        end
      end
      2'd2: begin
        if (head_y == '0) begin
          w_edge   = 1'b1;
          w_next_y = c_y_max;
        end else begin
          w_next_y = head_y - COORD_WIDTH'(1);
        end
      end
      default: begin
        if (head_y >= c_y_max) begin
          w_edge   = 1'b1;
          w_next_y = '0;
        end else begin
          w_next_y = head_y + COORD_WIDTH'(1);
        end
      end
    endcase
  end

`ifdef WRAP_AROUND_EN
  assign w_out_of_bounds = 1'b0;
`else
  assign w_out_of_bounds = w_edge;
`endif

  // Length arithmetic is done two bits wider so +2 can never wrap before saturation.
  always_comb begin
    w_len_ext = {2'b00, snake_length};
    w_len_sum = w_len_ext;
    case (fruit_type)
      2'd0:    w_len_sum = w_len_ext + c_len_ext_w'(1);
      2'd1:    w_len_sum = w_len_ext + c_len_ext_w'(2);
      2'd2:    w_len_sum = (w_len_ext > c_len_min) ? (w_len_ext - c_len_ext_w'(1)) : c_len_min;
      default: w_len_sum = w_len_ext;
    endcase
    if (w_len_sum > c_len_max) begin
      w_len_sum = c_len_max;
    end
  end

  assign w_fruit_len = w_len_sum[LENGTH_WIDTH-1:0];
  assign w_lives_inc = (lives == c_lives_max) ? lives : (lives + 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_RESPAWN;
      S_RUN:     if (r_tick_cnt == c_tick_last) w_next_state = S_MOVE;
      S_MOVE:    w_next_state = w_out_of_bounds ? S_HIT : S_CHECK;
      S_CHECK:   w_next_state = body_hit ? S_HIT : S_RUN;
      S_HIT:     w_next_state = (lives <= 3'd1) ? S_OVER : S_RESPAWN;
      S_RESPAWN: w_next_state = S_RUN;
      S_OVER:    if (start) w_next_state = S_RESPAWN;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_x        <= c_start_x;
      head_y        <= c_start_y;
      direction     <= 2'd0;
      snake_length  <= c_start_len;
      lives         <= c_start_lives;
      move_strobe   <= 1'b0;
      grow          <= 1'b0;
      respawn       <= 1'b0;
      game_over     <= 1'b0;
      r_tick_cnt    <= '0;
      r_pending_dir <= 2'd0;
    end else begin
      move_strobe <= 1'b0;
      grow        <= 1'b0;
      respawn     <= 1'b0;
      game_over   <= (w_next_state == S_OVER);
      if (dir_valid) begin
        r_pending_dir <= dir_in;
      end
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) lives <= c_start_lives;
        end
        S_RUN: begin
          r_tick_cnt <= (r_tick_cnt == c_tick_last) ? '0 : (r_tick_cnt + c_tick_w'(1));
        end
        S_MOVE: begin
          direction <= w_move_dir;
          if (!w_out_of_bounds) begin
            head_x      <= w_next_x;
            head_y      <= w_next_y;
            move_strobe <= 1'b1;
          end
        end
        S_CHECK: begin
          // A self-collision takes priority; any fruit on that move is forfeited.
          if (!body_hit && food_eaten) begin
            if (fruit_type == 2'd3) begin
              lives <= w_lives_inc;
            end else begin
              snake_length <= w_fruit_len;
              grow         <= ~fruit_type[1];
            end
          end
        end
        S_HIT: begin
          lives <= (lives == 3'd0) ? 3'd0 : (lives - 3'd1);
        end
        S_RESPAWN: begin
          head_x        <= c_start_x;
          head_y        <= c_start_y;
          snake_length  <= c_start_len;
          direction     <= 2'd0;
          r_pending_dir <= 2'd0;
          r_tick_cnt    <= '0;
          respawn       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_game_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snake_game_controller                                                 |
// | Randomised bench for snake_game_controller against a game-rule model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_snake_game_controller;

  localparam int CW   = 10;
  localparam int LW   = 6;
  localparam int TD   = 4;
  localparam int SX   = 10;
  localparam int SY   = 10;
  localparam int SL   = 3;
  localparam int SLV  = 3;
  localparam int DW   = 64;
  localparam int DH   = 48;
  localparam int MAXL = 63;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_MOVE  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_HIT   = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;
  localparam logic [2:0] ST_OVER  = 3'd6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    dir_in;
  logic          dir_valid;
  logic          body_hit;
  logic          food_eaten;
  logic [1:0]    fruit_type;
  logic [CW-1:0] head_x;
  logic [CW-1:0] head_y;
  logic [1:0]    direction;
  logic          move_strobe;
  logic          grow;
  logic [LW-1:0] snake_length;
  logic [2:0]    lives;
  logic          respawn;
  logic          game_over;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cyc = 0;

  // Game-level model: position, heading, pending request, length, lives.
  int m_x, m_y, m_dir, m_pend, m_len, m_lives;
  bit m_over;

  snake_game_controller #(
    .COORD_WIDTH(CW), .LENGTH_WIDTH(LW), .MAX_LENGTH(MAXL),
    .DISPLAY_WIDTH(DW), .DISPLAY_HEIGHT(DH), .TICK_DIV(TD),
    .START_X(SX), .START_Y(SY), .START_LENGTH(SL), .START_LIVES(SLV)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir_in(dir_in), .dir_valid(dir_valid),
    .body_hit(body_hit), .food_eaten(food_eaten), .fruit_type(fruit_type),
    .head_x(head_x), .head_y(head_y), .direction(direction), .move_strobe(move_strobe),
    .grow(grow), .snake_length(snake_length), .lives(lives), .respawn(respawn),
    .game_over(game_over), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_respawn();
    m_x = SX; m_y = SY; m_dir = 0; m_pend = 0; m_len = SL;
  endtask

  // Start from IDLE or OVER; leaves the DUT in its first RUN cycle.
  task automatic do_start(input bit hold);
    start = 1'b1;
    @(negedge clk);
    m_lives = SLV;
    m_over  = 1'b0;
    checks++;
    if ({state, lives} !== {ST_RESP, 3'(SLV)}) begin
      errors++;
      $display("FAIL start_load state=%0d lives=%0d exp state=%0d lives=%0d", state, lives, ST_RESP, SLV);
    end
    if (!hold) start = 1'b0;
    @(negedge clk);
    model_respawn();
    checks++;
    if ({state, respawn, head_x, head_y, direction, snake_length, lives, game_over} !==
        {ST_RUN, 1'b1, CW'(SX), CW'(SY), 2'd0, LW'(SL), 3'(SLV), 1'b0}) begin
      errors++;
      $display("FAIL start_respawn state=%0d resp=%0b head=(%0d,%0d) dir=%0d len=%0d lives=%0d over=%0b exp state=1 resp=1 head=(%0d,%0d) dir=0 len=%0d lives=%0d over=0",
               state, respawn, head_x, head_y, direction, snake_length, lives, game_over, SX, SY, SL, SLV);
    end
  endtask

  // One full move tick starting in the first RUN cycle.
  task automatic do_tick(input int nreq, input int d0, input int d1,
                         input bit bh, input bit fe, input int ft);
    int waited, nx, ny;
    bit out, g;
    logic [CW-1:0] ex, ey;
    logic [2:0] est;
    strobe_cyc = -1000;
    body_hit = bh; food_eaten = fe; fruit_type = 2'(ft);
    for (int i = 0; i < nreq; i++) begin
      dir_in = 2'((i == 0) ? d0 : d1);
      dir_valid = 1'b1;
      @(negedge clk);
      dir_valid = 1'b0;
      m_pend = (i == 0) ? d0 : d1;
    end
    waited = 0;
    while (state !== ST_MOVE && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (state !== ST_MOVE) begin
      errors++;
      $display("FAIL move_wait state=%0d exp=%0d", state, ST_MOVE);
      body_hit = 1'b0; food_eaten = 1'b0;
      return;
    end
    if (m_pend != opposite(m_dir)) m_dir = m_pend;
    nx = m_x + ((m_dir == 0) ? 1 : (m_dir == 1) ? -1 : 0);
    ny = m_y + ((m_dir == 3) ? 1 : (m_dir == 2) ? -1 : 0);
    out = (nx < 0) || (nx >= DW) || (ny < 0) || (ny >= DH);
`ifdef WRAP_AROUND_EN
    nx = (nx + DW) % DW;
    ny = (ny + DH) % DH;
    out = 1'b0;
`endif
    if (!out) begin
      m_x = nx; m_y = ny;
    end
    @(negedge clk);
    if (move_strobe === 1'b1) strobe_cyc = cyc;
    est = out ? ST_HIT : ST_CHECK;
    ex = CW'(m_x); ey = CW'(m_y);
    checks++;
    if ({state, move_strobe, head_x, head_y, direction} !== {est, ~out, ex, ey, 2'(m_dir)}) begin
      errors++;
      $display("FAIL move state=%0d strobe=%0b head=(%0d,%0d) dir=%0d exp state=%0d strobe=%0b head=(%0d,%0d) dir=%0d",
               state, move_strobe, head_x, head_y, direction, est, ~out, m_x, m_y, m_dir);
    end
    if (!out) begin
      g = 1'b0;
      if (!bh && fe) begin
        case (ft)
          0: begin m_len = (m_len + 1 > MAXL) ? MAXL : m_len + 1; g = 1'b1; end
          1: begin m_len = (m_len + 2 > MAXL) ? MAXL : m_len + 2; g = 1'b1; end
          2: m_len = (m_len - 1 < SL) ? SL : m_len - 1;
          default: m_lives = (m_lives < 7) ? m_lives + 1 : 7;
        endcase
      end
      @(negedge clk);
      est = bh ? ST_HIT : ST_RUN;
      checks++;
      if ({state, grow, snake_length, lives} !== {est, g, LW'(m_len), 3'(m_lives)}) begin
        errors++;
        $display("FAIL check state=%0d grow=%0b len=%0d lives=%0d exp state=%0d grow=%0b len=%0d lives=%0d",
                 state, grow, snake_length, lives, est, g, m_len, m_lives);
      end
      out = bh;
    end
    body_hit = 1'b0; food_eaten = 1'b0;
    if (out) begin
      m_lives--;
      m_over = (m_lives == 0);
      @(negedge clk);
      est = m_over ? ST_OVER : ST_RESP;
      checks++;
      if ({state, lives, game_over} !== {est, 3'(m_lives), m_over}) begin
        errors++;
        $display("FAIL hit state=%0d lives=%0d over=%0b exp state=%0d lives=%0d over=%0b",
                 state, lives, game_over, est, m_lives, m_over);
      end
      if (!m_over) begin
        model_respawn();
        @(negedge clk);
        checks++;
        if ({state, respawn, head_x, head_y, direction, snake_length} !==
            {ST_RUN, 1'b1, CW'(SX), CW'(SY), 2'd0, LW'(SL)}) begin
          errors++;
          $display("FAIL respawn state=%0d resp=%0b head=(%0d,%0d) dir=%0d len=%0d exp state=1 resp=1 head=(%0d,%0d) dir=0 len=%0d",
                   state, respawn, head_x, head_y, direction, snake_length, SX, SY, SL);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; dir_in = 2'd0; dir_valid = 1'b0;
    body_hit = 1'b0; food_eaten = 1'b0; fruit_type = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({state, head_x, head_y, direction, snake_length, lives, move_strobe, grow, respawn, game_over} !==
        {ST_IDLE, CW'(SX), CW'(SY), 2'd0, LW'(SL), 3'(SLV), 4'b0000}) begin
      errors++;
      $display("FAIL reset_values state=%0d head=(%0d,%0d) dir=%0d len=%0d lives=%0d pulses=%0b%0b%0b over=%0b exp state=0 head=(10,10) dir=0 len=3 lives=3 pulses=000 over=0",
               state, head_x, head_y, direction, snake_length, lives, move_strobe, grow, respawn, game_over);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_hold state=%0d exp=%0d", state, ST_IDLE);
    end
  endtask

  task automatic test_tick_period();
    int c1, c2;
    do_start(1'b0);
    do_tick(0, 0, 0, 0, 0, 0);
    c1 = strobe_cyc;
    do_tick(0, 0, 0, 0, 0, 0);
    c2 = strobe_cyc;
    checks++;
    if (c2 - c1 != TD + 2) begin
      errors++;
      $display("FAIL tick_period got=%0d exp=%0d", c2 - c1, TD + 2);
    end
    do_tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (strobe_cyc - c2 != TD + 2) begin
      errors++;
      $display("FAIL tick_period2 got=%0d exp=%0d", strobe_cyc - c2, TD + 2);
    end
    checks++;
    if (head_x !== CW'(13) || head_y !== CW'(10)) begin
      errors++;
      $display("FAIL three_ticks head=(%0d,%0d) exp=(13,10)", head_x, head_y);
    end
  endtask

  task automatic test_direction();
    do_tick(1, 1, 0, 0, 0, 0);
    checks++;
    if (direction !== 2'd0 || head_x !== CW'(14)) begin
      errors++;
      $display("FAIL reversal dir=%0d x=%0d exp dir=0 x=14", direction, head_x);
    end
    do_tick(1, 3, 0, 0, 0, 0);
    do_tick(2, 2, 3, 0, 0, 0);
    checks++;
    if (direction !== 2'd3) begin
      errors++;
      $display("FAIL last_request_wins dir=%0d exp=3", direction);
    end
    do_tick(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fruit();
    do_tick(0, 0, 0, 0, 1, 1);
    checks++;
    if (snake_length !== LW'(5)) begin
      errors++;
      $display("FAIL fruit1 len=%0d exp=5", snake_length);
    end
    for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0, 1, 2);
    checks++;
    if (snake_length !== LW'(SL)) begin
      errors++;
      $display("FAIL shrink_floor len=%0d exp=%0d", snake_length, SL);
    end
    for (int i = 0; i < 5; i++) do_tick(1, (i % 2 == 0) ? 3 : 0, 0, 0, 1, 3);
    checks++;
    if (lives !== 3'd7) begin
      errors++;
      $display("FAIL lives_sat lives=%0d exp=7", lives);
    end
    for (int i = 0; i < 29; i++) do_tick(1, (i % 2 == 0) ? 3 : 0, 0, 0, 1, 1);
    do_tick(0, 0, 0, 0, 1, 0);
    checks++;
    if (snake_length !== LW'(62)) begin
      errors++;
      $display("FAIL len62 len=%0d exp=62", snake_length);
    end
    do_tick(0, 0, 0, 0, 1, 1);
    do_tick(0, 0, 0, 0, 1, 0);
    checks++;
    if (snake_length !== LW'(MAXL)) begin
      errors++;
      $display("FAIL len_sat len=%0d exp=%0d", snake_length, MAXL);
    end
  endtask

  task automatic test_wall();
    int lv;
    for (int i = 0; i < DW && m_x < DW - 1; i++) do_tick(1, 0, 0, 0, 0, 0);
    lv = m_lives;
    do_tick(1, 0, 0, 0, 0, 0);
    checks++;
`ifdef WRAP_AROUND_EN
    if (head_x !== CW'(0) || lives !== 3'(lv)) begin
      errors++;
      $display("FAIL wall_right x=%0d lives=%0d exp x=0 lives=%0d", head_x, lives, lv);
    end
`else
    if (head_x !== CW'(SX) || head_y !== CW'(SY) || snake_length !== LW'(SL) || lives !== 3'(lv - 1)) begin
      errors++;
      $display("FAIL wall_right head=(%0d,%0d) len=%0d lives=%0d exp head=(%0d,%0d) len=%0d lives=%0d",
               head_x, head_y, snake_length, lives, SX, SY, SL, lv - 1);
    end
`endif
    for (int i = 0; i < DH && m_y > 0; i++) do_tick(1, 2, 0, 0, 0, 0);
    lv = m_lives;
    do_tick(1, 2, 0, 0, 0, 0);
    checks++;
`ifdef WRAP_AROUND_EN
    if (head_y !== CW'(DH - 1) || lives !== 3'(lv)) begin
      errors++;
      $display("FAIL wall_up y=%0d lives=%0d exp y=%0d lives=%0d", head_y, lives, DH - 1, lv);
    end
`else
    if (lives !== 3'(lv - 1)) begin
      errors++;
      $display("FAIL wall_up lives=%0d exp=%0d", lives, lv - 1);
    end
`endif
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 8 && m_lives > 1; i++) do_tick(0, 0, 0, 1, 0, 0);
    do_tick(0, 0, 0, 0, 1, 1);
    do_tick(0, 0, 0, 1, 1, 0);
    checks++;
    if ({game_over, lives, snake_length} !== {1'b1, 3'd0, LW'(5)}) begin
      errors++;
      $display("FAIL game_over over=%0b lives=%0d len=%0d exp over=1 lives=0 len=5", game_over, lives, snake_length);
    end
    repeat (8) @(negedge clk);
    checks++;
    if ({state, game_over, head_x, head_y, snake_length, lives} !==
        {ST_OVER, 1'b1, CW'(m_x), CW'(m_y), LW'(m_len), 3'(m_lives)}) begin
      errors++;
      $display("FAIL over_frozen state=%0d over=%0b head=(%0d,%0d) len=%0d lives=%0d exp state=6 over=1 head=(%0d,%0d) len=%0d lives=%0d",
               state, game_over, head_x, head_y, snake_length, lives, m_x, m_y, m_len, m_lives);
    end
    do_start(1'b1);
    do_tick(0, 0, 0, 0, 0, 0);
    start = 1'b0;
    checks++;
    if (state !== ST_RUN || lives !== 3'(SLV)) begin
      errors++;
      $display("FAIL restart_held state=%0d lives=%0d exp state=1 lives=%0d", state, lives, SLV);
    end
  endtask

  task automatic test_random();
    int nreq, d0, d1, ft;
    bit bh, fe;
    for (int i = 0; i < 60; i++) begin
      if (m_over) do_start(1'b0);
      nreq = int'($urandom_range(0, 2));
      d0   = int'($urandom_range(0, 3));
      d1   = int'($urandom_range(0, 3));
      ft   = int'($urandom_range(0, 3));
      bh   = ($urandom_range(0, 9) == 0);
      fe   = ($urandom_range(0, 1) == 1);
      do_tick(nreq, d0, d1, bh, fe, ft);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    if (m_over) do_start(1'b0);
    waited = 0;
    while (state !== ST_CHECK && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (state !== ST_CHECK || move_strobe !== 1'b1) begin
      errors++;
      $display("FAIL reach_check state=%0d strobe=%0b exp state=3 strobe=1", state, move_strobe);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, head_x, head_y, direction, snake_length, lives, move_strobe, grow, respawn, game_over} !==
        {ST_IDLE, CW'(SX), CW'(SY), 2'd0, LW'(SL), 3'(SLV), 4'b0000}) begin
      errors++;
      $display("FAIL async_reset state=%0d head=(%0d,%0d) dir=%0d len=%0d lives=%0d strobe=%0b exp state=0 head=(10,10) dir=0 len=3 lives=3 strobe=0",
               state, head_x, head_y, direction, snake_length, lives, move_strobe);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_start(1'b0);
    do_tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_direction();
    test_fruit();
    test_wall();
    test_game_over();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_game_controller.md
Name: snake_game_controller

Overview:
Top-level sequencer for the snake game datapath. It divides the system clock into move ticks and steps the snake head once per tick. It strobes the body shift and samples the downstream collision_detection and fruit_generator_counter results. It owns lives and snake length, and runs the idle / play / respawn / game-over flow.

Parameters:
- COORD_WIDTH, 10, head coordinate width
- LENGTH_WIDTH, 6, snake length width
- MAX_LENGTH, 63, length saturation value
- DISPLAY_WIDTH, 64, playfield columns; legal x is 0..63
- DISPLAY_HEIGHT, 48, playfield rows; legal y is 0..47
- TICK_DIV, 10, clocks per move tick; must be at least 2
- START_X, 10, respawn head x
- START_Y, 10, respawn head y
- START_LENGTH, 3, respawn and reset length; also the minimum length
- START_LIVES, 3, lives at game start

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; starts a game from IDLE or OVER
- dir_in  in  2  requested direction: 0 right, 1 left, 2 up, 3 down
- dir_valid  in  1  qualifies dir_in for one cycle
- body_hit  in  1  self-collision flag from collision_detection, valid during CHECK
- food_eaten  in  1  flag from fruit_generator_counter, valid during CHECK
- fruit_type  in  2  type of the eaten fruit
- head_x  out  COORD_WIDTH  current head x
- head_y  out  COORD_WIDTH  current head y
- direction  out  2  direction currently applied
- move_strobe  out  1  one-cycle pulse; body shifts by one segment
- grow  out  1  one-cycle pulse; tail is retained on this move
- snake_length  out  LENGTH_WIDTH  current length
- lives  out  3  remaining lives
- respawn  out  1  one-cycle pulse; body reinitialises
- game_over  out  1  high while in OVER
- state  out  3  FSM state, for debug

Behaviour:
- Reset while reset=0, asynchronous, all outputs registered:
  - state IDLE; head (START_X, START_Y); direction 0.
  - snake_length START_LENGTH; lives START_LIVES.
  - All pulses 0; game_over 0; tick counter 0; pending direction 0.
- State encoding: IDLE=0, RUN=1, MOVE=2, CHECK=3, HIT=4, RESPAWN=5, OVER=6.
- IDLE:
  - start=1 -> RESPAWN, with lives loaded to START_LIVES.
- RUN:
  - Tick counter counts 0..TICK_DIV-1.
  - At TICK_DIV-1: counter clears, next state MOVE.
  - Exactly TICK_DIV clocks are spent in RUN per tick.
- Direction latch, active in every state:
  - dir_valid=1 captures dir_in into pending_dir.
  - A later request in the same tick overwrites it (last wins).
- MOVE:
  - If pending_dir == direction^1 (reversal), the request is discarded; otherwise direction <= pending_dir.
  - Next head: right x+1, left x-1, up y-1, down y+1.
  - If next x is outside 0..DISPLAY_WIDTH-1 or next y is outside 0..DISPLAY_HEIGHT-1 (decrement from 0 counts as out): head is unchanged, go to HIT.
  - Otherwise head is updated, move_strobe=1 for the following cycle, go to CHECK.
- CHECK, one cycle; body_hit and food_eaten are sampled at its closing edge:
  - body_hit=1 -> HIT. Food is ignored when both are set.
  - food_eaten=1 -> apply fruit rule, then RUN.
  - Neither set -> RUN.
- Fruit rule by fruit_type:
  - 0: length +1, grow pulse.
  - 1: length +2, grow pulse.
  - 2: length -1, floor START_LENGTH.
  - 3: lives +1, saturate at 7.
  - Length saturates at MAX_LENGTH.
  - grow is asserted on the cycle after CHECK.
- HIT:
  - lives decrements.
  - Result 0 -> OVER; otherwise RESPAWN.
- RESPAWN, one cycle:
  - head (START_X, START_Y); length START_LENGTH; direction 0; pending_dir 0; tick counter 0.
  - respawn=1 on the next cycle; next state RUN.
- OVER:
  - game_over=1; head, length and lives are frozen.
  - start=1 -> RESPAWN, with lives=START_LIVES.
  - A start held continuously re-triggers only from IDLE or OVER.
- Reset asserted mid-operation:
  - Immediate return to reset values from any state.
  - Any pending pulse is cancelled.

Optional Feature:
- Macro: WRAP_AROUND_EN.
- Defined: a boundary exit wraps to the opposite edge and never goes to HIT.
  - x=63 moving right -> x=0.
  - y=0 moving up -> y=47.
  - move_strobe fires normally.
- Undefined: a boundary exit costs a life as described in Behaviour.

Test Plan:
1. TICK_DIV=4; reset low for 2 cycles, release, start=1 -> respawn pulse, state RUN, head (10,10), length 3, lives 3. move_strobe recurs every 6 clocks (4 RUN + MOVE + CHECK); after 3 ticks head is (13,10).
2. Direction 0 applied, dir_in=1 with dir_valid -> reversal rejected, head x still increments. Then dir_in=3 -> next move head y+1. Two requests (2 then 3) in one tick -> 3 applied.
3. food_eaten=1 in CHECK: fruit_type=1 -> length 3->5 with grow pulse; fruit_type=2 at length 3 -> stays 3; fruit_type=3 at lives 7 -> stays 7; 62 + type 1 -> 63.
4. Head (63,20) moving right, macro off -> HIT, lives 3->2, respawn to (10,10), length 3. Macro on -> head (0,20), lives unchanged.
5. body_hit=1 and food_eaten=1 together at lives=1 -> lives 0, game_over=1, length unchanged; start=1 -> lives 3, state RUN.
6. Reset asserted during CHECK with move_strobe high -> outputs return to reset values within the same cycle, move_strobe 0, state IDLE.
